// File: rtl/vera_video_pkg.sv
// Shared video timing constants for the display end of the composer:
// default progressive/interlaced timings, derived totals and counter widths.
package vera_video_pkg;

  localparam int unsigned H_W = 11;
  localparam int unsigned V_W = 10;

  localparam int unsigned P_H_ACTIVE = 640;
  localparam int unsigned P_H_FP     = 16;
  localparam int unsigned P_H_SYNC   = 96;
  localparam int unsigned P_H_BP     = 48;
  localparam int unsigned P_H_TOTAL  = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;

  localparam int unsigned P_V_ACTIVE = 480;
  localparam int unsigned P_V_FP     = 10;
  localparam int unsigned P_V_SYNC   = 2;
  localparam int unsigned P_V_BP     = 33;
  localparam int unsigned P_V_TOTAL  = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;

  localparam int unsigned I_H_TOTAL_DEF  = 1588;
  localparam int unsigned I_H_ACTIVE_DEF = 1280;
  localparam int unsigned I_H_SYNC_DEF   = 117;
  localparam int unsigned I_H_FP         = 32;
  localparam int unsigned I_V_ACTIVE_DEF = 240;
  localparam int unsigned I_V_SYNC_DEF   = 3;
  localparam int unsigned I_V_SYNC_OFS   = 3;
  localparam int unsigned I_V_TOTAL_F0   = 263;
  localparam int unsigned I_V_TOTAL_F1   = 262;

  typedef enum logic {
    MODE_PROG = 1'b0,
    MODE_INTL = 1'b1
  } scan_mode_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register whose stages load a caller-supplied value on
// asynchronous reset. DEPTH must be at least 1.
module sync_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= rst_val;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: pixel/line/frame strobes toward the composer and
// sync/blank/pixel outputs aligned with the composer's returned data.
module video_timing_gen
  import vera_video_pkg::*;
#(
  parameter int unsigned DATA_LATENCY = 2,
  parameter int unsigned H_ACTIVE     = P_H_ACTIVE,
  parameter int unsigned H_FP         = P_H_FP,
  parameter int unsigned H_SYNC       = P_H_SYNC,
  parameter int unsigned H_BP         = P_H_BP,
  parameter int unsigned V_ACTIVE     = P_V_ACTIVE,
  parameter int unsigned V_FP         = P_V_FP,
  parameter int unsigned V_SYNC       = P_V_SYNC,
  parameter int unsigned V_BP         = P_V_BP,
  parameter int unsigned I_H_TOTAL    = I_H_TOTAL_DEF,
  parameter int unsigned I_H_ACTIVE   = I_H_ACTIVE_DEF,
  parameter int unsigned I_H_SYNC     = I_H_SYNC_DEF,
  parameter int unsigned I_V_ACTIVE   = I_V_ACTIVE_DEF,
  parameter int unsigned I_V_SYNC     = I_V_SYNC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interlaced,
  input  logic [7:0] display_data,
  output logic       display_next_frame,
  output logic       display_next_line,
  output logic       display_next_pixel,
  output logic       display_current_field,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank,
  output logic [7:0] pixel_out
);

  localparam logic [H_W-1:0] PH_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [H_W-1:0] PH_ACT   = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] PH_HS0   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] PH_HS1   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] IH_LAST  = H_W'(I_H_TOTAL - 1);
  localparam logic [H_W-1:0] IH_ACT   = H_W'(I_H_ACTIVE);
  localparam logic [H_W-1:0] IH_HS0   = H_W'(I_H_ACTIVE + I_H_FP);
  localparam logic [H_W-1:0] IH_HS1   = H_W'(I_H_ACTIVE + I_H_FP + I_H_SYNC);
  localparam logic [H_W-1:0] IH_HALF  = H_W'(I_H_TOTAL / 2);
  localparam logic [V_W-1:0] PV_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [V_W-1:0] PV_ACT   = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] PV_VS0   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] PV_VS1   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] IV_LAST0 = V_W'(I_V_TOTAL_F0 - 1);
  localparam logic [V_W-1:0] IV_LAST1 = V_W'(I_V_TOTAL_F1 - 1);
  localparam logic [V_W-1:0] IV_ACT   = V_W'(I_V_ACTIVE);
  localparam logic [V_W-1:0] IV_VS0   = V_W'(I_V_ACTIVE + I_V_SYNC_OFS);
  localparam logic [V_W-1:0] IV_VS1   = V_W'(I_V_ACTIVE + I_V_SYNC_OFS + I_V_SYNC);

  scan_mode_t     mode_r;
  logic           field_r;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  logic [H_W-1:0] h_last, h_act, hs0, hs1;
  logic [V_W-1:0] v_last, v_act, vs0, vs1;
  logic           line_end, frame_end, act_raw, hs_raw_n, vs_raw_n;
  logic           act_d, hs_d, vs_d;

  always_comb begin
    if (mode_r == MODE_INTL) begin
      h_last = IH_LAST;
      h_act  = IH_ACT;
      hs0    = IH_HS0;
      hs1    = IH_HS1;
      v_last = field_r ? IV_LAST1 : IV_LAST0;
      v_act  = IV_ACT;
      vs0    = IV_VS0;
      vs1    = IV_VS1;
    end else begin
      h_last = PH_LAST;
      h_act  = PH_ACT;
      hs0    = PH_HS0;
      hs1    = PH_HS1;
      v_last = PV_LAST;
      v_act  = PV_ACT;
      vs0    = PV_VS0;
      vs1    = PV_VS1;
    end
    line_end  = (h_cnt == h_last);
    frame_end = line_end && (v_cnt == v_last);
    act_raw   = (h_cnt < h_act) && (v_cnt < v_act);
    hs_raw_n  = !((h_cnt >= hs0) && (h_cnt < hs1));
    vs_raw_n  = !((v_cnt >= vs0) && (v_cnt < vs1));
    // Field 1 vsync starts and ends half a line late.
    if (mode_r == MODE_INTL && field_r)
      vs_raw_n = !(((v_cnt == vs0) && (h_cnt >= IH_HALF)) ||
                   ((v_cnt > vs0) && (v_cnt < vs1)) ||
                   ((v_cnt == vs1) && (h_cnt < IH_HALF)));
  end

  assign display_next_pixel    = !rst && (h_cnt < h_act);
  assign display_next_line     = !rst && line_end;
  assign display_next_frame    = !rst && frame_end;
  assign display_current_field = field_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      mode_r  <= MODE_PROG;
      field_r <= 1'b0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + 1'b1;
      if (frame_end) begin
        v_cnt   <= '0;
        mode_r  <= interlaced ? MODE_INTL : MODE_PROG;
        field_r <= (interlaced && mode_r == MODE_INTL) ? ~field_r : 1'b0;
      end else if (line_end) begin
        v_cnt <= v_cnt + 1'b1;
      end
    end
  end

  // DATA_LATENCY stages here plus the output register below give the full
  // DATA_LATENCY+1 alignment; the pixel mux needs the tap one stage early.
  sync_delay_line #(
    .WIDTH(3),
    .DEPTH(DATA_LATENCY)
  ) u_sync_delay (
    .clk    (clk),
    .rst    (rst),
    .rst_val({1'b0, 1'b1, 1'b1}),
    .d      ({act_raw, hs_raw_n, vs_raw_n}),
    .q      ({act_d, hs_d, vs_d})
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_n   <= 1'b1;
      vsync_n   <= 1'b1;
      blank     <= 1'b1;
      pixel_out <= '0;
    end else begin
      hsync_n   <= hs_d;
      vsync_n   <= vs_d;
      blank     <= !act_d;
      pixel_out <= act_d ? display_data : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using shrunken timings so whole
// frames and fields fit in a short run.
module tb_video_timing_gen;

  localparam int unsigned NONE = 999999;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       interlaced = 1'b0;
  logic [7:0] display_data = 8'h00;
  logic       display_next_frame, display_next_line, display_next_pixel;
  logic       display_current_field, hsync_n, vsync_n, blank;
  logic [7:0] pixel_out;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Progressive: 32 clk lines (16 active, hsync 20..25), 20 lines, vsync 14..15.
  // Interlaced: 40 clk lines (4 active, hsync 36..38), vsync from line 23.
  video_timing_gen #(
    .DATA_LATENCY(2),
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .I_H_TOTAL(40), .I_H_ACTIVE(4), .I_H_SYNC(3),
    .I_V_ACTIVE(20), .I_V_SYNC(3)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .interlaced           (interlaced),
    .display_data         (display_data),
    .display_next_frame   (display_next_frame),
    .display_next_line    (display_next_line),
    .display_next_pixel   (display_next_pixel),
    .display_current_field(display_current_field),
    .hsync_n              (hsync_n),
    .vsync_n              (vsync_n),
    .blank                (blank),
    .pixel_out            (pixel_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Composer model: returns x (pixel index within line) two clocks after each
  // strobe, junk otherwise; expects pixel_out/blank three clocks after.
  logic [7:0]  dval [2];
  logic [7:0]  epix [3];
  logic        eblk [3];
  int unsigned mx, my, pix_errs = 0, blk_errs = 0;
  logic        cur_intl, act;

  always @(negedge clk) begin
    if (rst) begin
      mx = 0; my = 0; cur_intl = 1'b0;
      dval[0] = 8'h00; dval[1] = 8'h00;
      for (int i = 0; i < 3; i++) begin epix[i] = 8'h00; eblk[i] = 1'b1; end
      display_data = 8'h00;
    end else begin
      if (pixel_out !== epix[2]) pix_errs++;
      if (blank !== eblk[2]) blk_errs++;
      if (blank === 1'b1 && pixel_out !== 8'h00) blk_errs++;
      display_data = dval[1];
      act = display_next_pixel && (my < (cur_intl ? 20 : 12));
      dval[1] = dval[0];
      dval[0] = display_next_pixel ? 8'(mx) : 8'hC3;
      epix[2] = epix[1]; epix[1] = epix[0]; epix[0] = act ? 8'(mx) : 8'h00;
      eblk[2] = eblk[1]; eblk[1] = eblk[0]; eblk[0] = !act;
      if (display_next_pixel) mx++;
      if (display_next_line) begin mx = 0; my++; end
      if (display_next_frame) begin my = 0; cur_intl = interlaced; end
    end
  end

  int unsigned f_cyc, f_lines, f_frames, f_px, f_bad_len, f_bad_px, f_hs_err;
  int unsigned f_hs_low, f_vs_err, f_vs_first, f_fld0, f_fld_chg, f_overlap;

  task automatic run_frame(input int unsigned h_total, px_line, hs0, hs1,
                           vs_lo, vs_hi, raise_ln);
    int unsigned len, pxl, hpos, p, hs_ph;
    logic exp_low;
    f_cyc = 0; f_lines = 0; f_frames = 0; f_px = 0; f_bad_len = 0; f_bad_px = 0;
    f_hs_err = 0; f_hs_low = 0; f_vs_err = 0; f_vs_first = NONE; f_fld0 = 0;
    f_fld_chg = 0; f_overlap = 0; len = 0; pxl = 0; hpos = 0;
    while (f_frames == 0 && f_cyc < 12000) begin
      @(negedge clk);
      if (f_cyc == 0) f_fld0 = display_current_field;
      else if (display_current_field != f_fld0[0]) f_fld_chg++;
      f_cyc++;
      p = f_lines * h_total + hpos;
      hs_ph = (hpos + h_total - 3) % h_total;
      if (!(f_lines == 0 && hpos < 3)) begin
        exp_low = (hs_ph >= hs0) && (hs_ph < hs1);
        if (hsync_n !== !exp_low) f_hs_err++;
      end
      if (p >= 3) begin
        exp_low = (p >= vs_lo) && (p < vs_hi);
        if (vsync_n !== !exp_low) f_vs_err++;
      end
      if (hsync_n === 1'b0) f_hs_low++;
      if (vsync_n === 1'b0 && f_vs_first == NONE) f_vs_first = p;
      if (display_next_pixel) begin f_px++; pxl++; end
      if (display_next_pixel && display_next_line) f_overlap++;
      len++;
      if (raise_ln == f_lines && hpos == 0) #1 interlaced = 1'b1;
      if (display_next_frame) f_frames++;
      if (display_next_line) begin
        if (len != h_total) f_bad_len++;
        if (pxl != px_line) f_bad_px++;
        len = 0; pxl = 0; hpos = 0; f_lines++;
      end else begin
        hpos++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int unsigned cyc, lines, px,
                             hs_low, vs_first, fld);
    check({tag, "_frame_seen"}, f_frames, 1);
    check({tag, "_cycles"}, f_cyc, cyc);
    check({tag, "_lines"}, f_lines, lines);
    check({tag, "_pixels"}, f_px, px);
    check({tag, "_bad_len"}, f_bad_len, 0);
    check({tag, "_bad_px_line"}, f_bad_px, 0);
    check({tag, "_hs_err"}, f_hs_err, 0);
    check({tag, "_hs_low"}, f_hs_low, hs_low);
    check({tag, "_vs_err"}, f_vs_err, 0);
    check({tag, "_vs_first"}, f_vs_first, vs_first);
    check({tag, "_field"}, f_fld0, fld);
    check({tag, "_field_chg"}, f_fld_chg, 0);
    check({tag, "_overlap"}, f_overlap, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, {display_next_frame, display_next_line, display_next_pixel}, 0);
    check({tag, "_syncs_blank"}, {hsync_n, vsync_n, blank}, 3'b111);
    check({tag, "_pixel"}, pixel_out, 0);
    check({tag, "_field"}, display_current_field, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #2 rst = 1'b0;
    #1 check("first_px", display_next_pixel, 1);

    run_frame(32, 16, 20, 26, 451, 515, NONE);
    check_frame("prog1", 640, 20, 320, 120, 451, 0);

    run_frame(32, 16, 20, 26, 451, 515, 10);
    check_frame("prog_raise", 640, 20, 320, 120, 451, 0);

    run_frame(40, 4, 36, 39, 923, 1043, NONE);
    check_frame("intl_f0", 10520, 263, 1052, 787, 923, 0);

    run_frame(40, 4, 36, 39, 943, 1063, NONE);
    check_frame("intl_f1", 10480, 262, 1048, 786, 943, 1);

    @(posedge clk); #2 interlaced = 1'b0;
    run_frame(40, 4, 36, 39, 923, 1043, NONE);
    check_frame("intl_f0b", 10520, 263, 1052, 789, 923, 0);

    // Progressive again; stop at line 5, clock 10 and reset mid-line.
    repeat (171) @(negedge clk);
    check("pre_rst_px", display_next_pixel, 1);
    check("pre_rst_pixel", pixel_out, 7);
    check("pre_rst_blank", blank, 0);
    check("pre_rst_field", display_current_field, 0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("restart_px", display_next_pixel, 1);
    run_frame(32, 16, 20, 26, 451, 515, NONE);
    check_frame("restart", 640, 20, 320, 120, 451, 0);

    check("pixel_align_errs", pix_errs, 0);
    check("blank_pixel_errs", blk_errs, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Video timing generator at the display end of the composer interface. It produces the `display_next_frame`, `display_next_line` and `display_next_pixel` strobes and the `display_current_field` level that the composer consumes. It takes the composer's `display_data` back, aligns it with delayed sync and blank signals, and drives the palette/DAC stage. It supports 640x480@60 progressive VGA and 480i interlaced mode, with 2x horizontal clocks per line in interlaced mode.

## Interface
Parameters:
- `DATA_LATENCY`, default 2: clk cycles from a `display_next_pixel` strobe to valid `display_data` for that pixel.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640/16/96/48: progressive horizontal timing (total 800).
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480/10/2/33: progressive vertical timing (total 525).
- `I_H_TOTAL`, `I_H_ACTIVE`, `I_H_SYNC`, defaults 1588/1280/117: interlaced line timing. Front porch is fixed at 32.
- `I_V_ACTIVE`, `I_V_SYNC`, defaults 240/3: interlaced active lines and vsync lines per field.

Ports (reset `rst` is asynchronous, active-high; clock `clk`):
- `clk` in 1: pixel clock, 25 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `interlaced` in 1: requested mode.
- `display_data` in 8: composed pixel index from the composer.
- `display_next_frame` out 1: one-cycle strobe at frame/field end.
- `display_next_line` out 1: one-cycle strobe at line end.
- `display_next_pixel` out 1: one-cycle strobe per active clock.
- `display_current_field` out 1: field being displayed. Held at 0 in progressive mode.
- `hsync_n`, `vsync_n` out 1 each: active-low syncs, aligned with `pixel_out`.
- `blank` out 1: high outside the active area, aligned with `pixel_out`.
- `pixel_out` out 8: `display_data` during active, 0 during blank.

## Operation
- `h_cnt` wraps at H_TOTAL-1, where H_TOTAL is 800 in progressive mode and I_H_TOTAL in interlaced mode. `v_cnt` increments when `h_cnt` wraps.
- Frame length:
  - Progressive: 525 lines.
  - Interlaced: field 0 is 263 lines, field 1 is 262 lines.
- Active region: `h_cnt` < H_ACTIVE (or I_H_ACTIVE) and `v_cnt` < V_ACTIVE (or I_V_ACTIVE).
- `display_next_pixel` is asserted on every clk where `h_cnt` is inside the horizontal active range. This applies on all lines, so the composer's x counter runs on blank lines too.
- `display_next_line` is asserted when `h_cnt` == H_TOTAL-1, on every line.
- `display_next_frame` is asserted together with `display_next_line` on the last line of the frame or field.
- `display_current_field` toggles in the cycle after `display_next_frame` in interlaced mode. It is held at 0 in progressive mode.
- `interlaced` is sampled into the internal `mode_r` only on the `display_next_frame` cycle. Mid-frame changes have no effect until then.
- On entering progressive mode, `display_current_field` is cleared to 0.
- Sync generation:
  - `hsync_n` is low for `h_cnt` in [active+FP, active+FP+SYNC).
  - `vsync_n` is low for SYNC lines starting at line V_ACTIVE+V_FP (progressive) or I_V_ACTIVE+3 (interlaced).
  - In interlaced field 1, the vsync edges shift by I_H_TOTAL/2 clocks (half line).
- Alignment: raw active, `hsync_n` and `vsync_n` pass through a DATA_LATENCY+1 stage delay line. `pixel_out` is registered as `active_d ? display_data : 0`.

## Timing
- Reset values:
  - `h_cnt` = 0, `v_cnt` = 0, `mode_r` = 0.
  - All strobes = 0, `display_current_field` = 0.
  - `hsync_n` = 1, `vsync_n` = 1, `blank` = 1, `pixel_out` = 0.
  - Delay line is filled with the inactive state.
- The first `display_next_pixel` occurs in the first cycle after `rst` deasserts.
- Strobes are combinational decodes of the registered counters. They are high for exactly one clk.
- `display_next_pixel` and `display_next_line` are never high in the same cycle.
- `pixel_out` for a pixel strobed at cycle t appears at t+DATA_LATENCY+1.
- Reset asserted mid-line returns the block to the reset state asynchronously. It restarts at `h_cnt` = 0, `v_cnt` = 0 on release.

## Structure
- Package `vera_video_pkg` holds the progressive and interlaced timing localparams, the derived H_TOTAL/V_TOTAL values, and the counter widths (h 11 bits, v 10 bits).
- Sub-module `sync_delay_line`: parameterised width and depth shift register with asynchronous reset value input. One instance carries {active, `hsync_n`, `vsync_n`}.

## Test plan
- Progressive mode after reset, one frame: exactly 640 `display_next_pixel` pulses per line, 525 `display_next_line` pulses and 1 `display_next_frame` pulse. `hsync_n` is low for 96 clks starting at `h_cnt` 656, shifted by DATA_LATENCY+1.
- Progressive `vsync_n`: low exactly on lines 490-491. `display_current_field` stays 0 throughout.
- Interlaced mode: line length 1588 clks with 1280 pixel strobes. Fields alternate 263 and 262 lines. `display_current_field` toggles one cycle after each `display_next_frame`. Field 1 vsync falling edge is offset by 794 clks.
- `interlaced` raised at line 100: line length stays 800 until after `display_next_frame`, then changes to 1588.
- `display_data` driven with `h_cnt[7:0]` at latency 2: `pixel_out` equals the strobed pixel's value with no off-by-one. `pixel_out` is 0 whenever `blank` = 1.
- `rst` pulsed at `h_cnt` 300, `v_cnt` 50: all outputs return to their reset values immediately. After release the counters restart at 0,0 and the first `display_next_frame` arrives 525 lines later.
